// File: rtl/pixel_gen_pkg.sv
// Shared constants and helpers for the test-pattern video source and its
// AXI-Lite register file.
package pixel_gen_pkg;

    localparam int REG_BLUE  = 0;
    localparam int REG_MODE  = 1;
    localparam int REG_FRAME = 7;

    localparam logic [1:0] RESP_OKAY = 2'b00;
    localparam logic [7:0] GRID_BLUE = 8'hFF;

    // Grid lines fall on every 32nd column and row when grid mode is enabled.
    function automatic logic [7:0] blue_of(
        input logic [4:0] x_lo,
        input logic [4:0] y_lo,
        input logic       grid_en,
        input logic [7:0] base
    );
        return (grid_en && (x_lo == 5'd0 || y_lo == 5'd0)) ? GRID_BLUE : base;
    endfunction

endpackage

// File: rtl/axi_lite_regs.sv
// AXI4-Lite slave with a small register file; the top entry of the map is a
// read-only frame counter advanced by a pulse from the pixel generator.
module axi_lite_regs
    import pixel_gen_pkg::*;
#(
    parameter int REG_FILE_SIZE = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  i_awaddr,
    input  logic        i_awvalid,
    output logic        o_awready,
    input  logic [31:0] i_wdata,
    input  logic        i_wvalid,
    output logic        o_wready,
    output logic [1:0]  o_bresp,
    output logic        o_bvalid,
    input  logic        i_bready,
    input  logic [7:0]  i_araddr,
    input  logic        i_arvalid,
    output logic        o_arready,
    output logic [31:0] o_rdata,
    output logic [1:0]  o_rresp,
    output logic        o_rvalid,
    input  logic        i_rready,
    input  logic        i_frame_inc,
    output logic [7:0]  o_blue,
    output logic        o_grid_en
);

    localparam int IW = $clog2(REG_FILE_SIZE);

    logic          r_aw_w_ready;
    logic          r_bvalid;
    logic          r_arready;
    logic          r_rvalid;
    logic [31:0]   r_rdata;
    logic          w_wr_en;
    logic          w_rd_en;
    logic [IW-1:0] w_wr_idx;
    logic [IW-1:0] w_rd_idx;
    logic [31:0]   w_regs [REG_FILE_SIZE];
    logic          w_unused_addr;

    // Only the word index bits select a register; the rest alias.
    assign w_wr_idx      = i_awaddr[2 +: IW];
    assign w_rd_idx      = i_araddr[2 +: IW];
    assign w_unused_addr = ^{i_awaddr, i_araddr};

    assign w_wr_en = r_aw_w_ready & i_awvalid & i_wvalid;
    assign w_rd_en = r_arready & i_arvalid;

    genvar gi;
    generate
        for (gi = 0; gi < REG_FILE_SIZE; gi++) begin : g_reg
            logic [31:0] r_val;
            if (gi == REG_FRAME) begin : g_frame
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        r_val <= '0;
                    end else if (i_frame_inc) begin
                        r_val <= r_val + 32'd1;
                    end
                end
            end else begin : g_rw
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        r_val <= '0;
                    end else if (w_wr_en && w_wr_idx == IW'(gi)) begin
                        r_val <= i_wdata;
                    end
                end
            end
            assign w_regs[gi] = r_val;
        end
    endgenerate

    // Ready is a one-cycle pulse; the !ready term stops a second accept
    // before bvalid/rvalid has had a chance to rise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_aw_w_ready <= 1'b0;
            r_bvalid     <= 1'b0;
            r_arready    <= 1'b0;
            r_rvalid     <= 1'b0;
            r_rdata      <= '0;
        end else begin
            r_aw_w_ready <= i_awvalid & i_wvalid & ~r_bvalid & ~r_aw_w_ready;
            if (w_wr_en) begin
                r_bvalid <= 1'b1;
            end else if (i_bready) begin
                r_bvalid <= 1'b0;
            end

            r_arready <= i_arvalid & ~r_rvalid & ~r_arready;
            if (w_rd_en) begin
                r_rvalid <= 1'b1;
                r_rdata  <= w_regs[w_rd_idx];
            end else if (i_rready) begin
                r_rvalid <= 1'b0;
            end
        end
    end

    assign o_awready = r_aw_w_ready;
    assign o_wready  = r_aw_w_ready;
    assign o_bvalid  = r_bvalid;
    assign o_bresp   = RESP_OKAY;
    assign o_arready = r_arready;
    assign o_rvalid  = r_rvalid;
    assign o_rdata   = r_rdata;
    assign o_rresp   = RESP_OKAY;
    assign o_blue    = w_regs[REG_BLUE][7:0];
    assign o_grid_en = w_regs[REG_MODE][0];

endmodule

// File: rtl/pixel_generator.sv
// Raster-order test-pattern source on AXI4-Stream, one pixel per beat, with
// the pattern configured through an AXI-Lite register file.
module pixel_generator
    import pixel_gen_pkg::*;
#(
    parameter int X_SIZE        = 640,
    parameter int Y_SIZE        = 480,
    parameter int REG_FILE_SIZE = 8
) (
    input  logic        out_stream_aclk,
    input  logic        s_axi_lite_aclk,
    input  logic        axi_resetn,
    input  logic        periph_resetn,
    output logic [31:0] out_stream_tdata,
    output logic [3:0]  out_stream_tkeep,
    output logic        out_stream_tlast,
    input  logic        out_stream_tready,
    output logic        out_stream_tvalid,
    output logic        out_stream_tuser,
    input  logic [7:0]  s_axi_lite_awaddr,
    input  logic        s_axi_lite_awvalid,
    output logic        s_axi_lite_awready,
    input  logic [31:0] s_axi_lite_wdata,
    input  logic        s_axi_lite_wvalid,
    output logic        s_axi_lite_wready,
    output logic [1:0]  s_axi_lite_bresp,
    output logic        s_axi_lite_bvalid,
    input  logic        s_axi_lite_bready,
    input  logic [7:0]  s_axi_lite_araddr,
    input  logic        s_axi_lite_arvalid,
    output logic        s_axi_lite_arready,
    output logic [31:0] s_axi_lite_rdata,
    output logic [1:0]  s_axi_lite_rresp,
    output logic        s_axi_lite_rvalid,
    input  logic        s_axi_lite_rready
);

    localparam int XW = $clog2(X_SIZE);
    localparam int YW = $clog2(Y_SIZE);
    localparam logic [XW-1:0] X_LAST = XW'(X_SIZE - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(Y_SIZE - 1);

    logic [XW-1:0] r_x;
    logic [YW-1:0] r_y;
    logic          r_tvalid;
    logic          r_tuser;
    logic          r_tlast;
    logic [31:0]   r_tdata;
    logic [XW-1:0] w_x_nxt;
    logic [YW-1:0] w_y_nxt;
    logic          w_adv;
    logic          w_x_last;
    logic          w_y_last;
    logic          w_frame_inc;
    logic [7:0]    w_blue_base;
    logic          w_grid_en;
    logic [7:0]    w_blue;
    logic          w_unused;

    // The AXI-Lite clock is the same net as the stream clock.
    assign w_unused = s_axi_lite_aclk;

    assign w_adv       = r_tvalid & out_stream_tready;
    assign w_x_last    = (r_x == X_LAST);
    assign w_y_last    = (r_y == Y_LAST);
    assign w_frame_inc = w_adv & w_x_last & w_y_last;

    always_comb begin
        w_x_nxt = r_x;
        w_y_nxt = r_y;
        if (w_adv) begin
            if (w_x_last) begin
                w_x_nxt = '0;
                w_y_nxt = w_y_last ? '0 : r_y + YW'(1);
            end else begin
                w_x_nxt = r_x + XW'(1);
            end
        end
    end

    assign w_blue = blue_of(5'(w_x_nxt), 5'(w_y_nxt), w_grid_en, w_blue_base);

    // The beat register is loaded with the pixel at the next position, so it
    // always describes the current (x,y); it is frozen while the sink stalls.
    always_ff @(posedge out_stream_aclk or negedge periph_resetn) begin
        if (!periph_resetn) begin
            r_x      <= '0;
            r_y      <= '0;
            r_tvalid <= 1'b0;
            r_tuser  <= 1'b0;
            r_tlast  <= 1'b0;
            r_tdata  <= '0;
        end else begin
            r_tvalid <= 1'b1;
            if (w_adv || !r_tvalid) begin
                r_x     <= w_x_nxt;
                r_y     <= w_y_nxt;
                r_tdata <= {8'h00, 8'(w_x_nxt), 8'(w_y_nxt), w_blue};
                r_tuser <= (w_x_nxt == '0) && (w_y_nxt == '0);
                r_tlast <= (w_x_nxt == X_LAST);
            end
        end
    end

    assign out_stream_tdata  = r_tdata;
    assign out_stream_tkeep  = 4'hF;
    assign out_stream_tlast  = r_tlast;
    assign out_stream_tvalid = r_tvalid;
    assign out_stream_tuser  = r_tuser;

    axi_lite_regs #(
        .REG_FILE_SIZE (REG_FILE_SIZE)
    ) u_regs (
        .clk         (out_stream_aclk),
        .rst_n       (axi_resetn),
        .i_awaddr    (s_axi_lite_awaddr),
        .i_awvalid   (s_axi_lite_awvalid),
        .o_awready   (s_axi_lite_awready),
        .i_wdata     (s_axi_lite_wdata),
        .i_wvalid    (s_axi_lite_wvalid),
        .o_wready    (s_axi_lite_wready),
        .o_bresp     (s_axi_lite_bresp),
        .o_bvalid    (s_axi_lite_bvalid),
        .i_bready    (s_axi_lite_bready),
        .i_araddr    (s_axi_lite_araddr),
        .i_arvalid   (s_axi_lite_arvalid),
        .o_arready   (s_axi_lite_arready),
        .o_rdata     (s_axi_lite_rdata),
        .o_rresp     (s_axi_lite_rresp),
        .o_rvalid    (s_axi_lite_rvalid),
        .i_rready    (s_axi_lite_rready),
        .i_frame_inc (w_frame_inc),
        .o_blue      (w_blue_base),
        .o_grid_en   (w_grid_en)
    );

endmodule

// File: tb/tb_pixel_generator.sv
// Self-checking bench for pixel_generator: a beat-index reference model of the
// raster plus a shadow copy of the register file.
module tb_pixel_generator;

    localparam int X  = 128;
    localparam int Y  = 24;
    localparam int XY = X * Y;

    logic        clk = 1'b0;
    logic        axi_resetn = 1'b0;
    logic        periph_resetn = 1'b0;
    logic [31:0] out_stream_tdata;
    logic [3:0]  out_stream_tkeep;
    logic        out_stream_tlast;
    logic        out_stream_tready = 1'b1;
    logic        out_stream_tvalid;
    logic        out_stream_tuser;
    logic [7:0]  awaddr = '0;
    logic        awvalid = 1'b0;
    logic        awready;
    logic [31:0] wdata = '0;
    logic        wvalid = 1'b0;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready = 1'b0;
    logic [7:0]  araddr = '0;
    logic        arvalid = 1'b0;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready = 1'b0;

    int          n_checks = 0;
    int          n_fail = 0;
    logic [31:0] shadow [8];
    int          m_k = 0;
    logic        m_valid = 1'b0;
    int unsigned m_frames = 0;

    always #5 clk = ~clk;

    pixel_generator #(.X_SIZE(X), .Y_SIZE(Y), .REG_FILE_SIZE(8)) dut (
        .out_stream_aclk    (clk),
        .s_axi_lite_aclk    (clk),
        .axi_resetn         (axi_resetn),
        .periph_resetn      (periph_resetn),
        .out_stream_tdata   (out_stream_tdata),
        .out_stream_tkeep   (out_stream_tkeep),
        .out_stream_tlast   (out_stream_tlast),
        .out_stream_tready  (out_stream_tready),
        .out_stream_tvalid  (out_stream_tvalid),
        .out_stream_tuser   (out_stream_tuser),
        .s_axi_lite_awaddr  (awaddr),
        .s_axi_lite_awvalid (awvalid),
        .s_axi_lite_awready (awready),
        .s_axi_lite_wdata   (wdata),
        .s_axi_lite_wvalid  (wvalid),
        .s_axi_lite_wready  (wready),
        .s_axi_lite_bresp   (bresp),
        .s_axi_lite_bvalid  (bvalid),
        .s_axi_lite_bready  (bready),
        .s_axi_lite_araddr  (araddr),
        .s_axi_lite_arvalid (arvalid),
        .s_axi_lite_arready (arready),
        .s_axi_lite_rdata   (rdata),
        .s_axi_lite_rresp   (rresp),
        .s_axi_lite_rvalid  (rvalid),
        .s_axi_lite_rready  (rready)
    );

    // Reference position: beat index within the frame, advanced per accepted beat.
    always @(posedge clk or negedge periph_resetn) begin
        if (!periph_resetn) begin
            m_k     <= 0;
            m_valid <= 1'b0;
        end else begin
            if (m_valid && out_stream_tready) begin
                if (m_k == XY - 1) begin
                    m_k      <= 0;
                    m_frames <= m_frames + 1;
                end else begin
                    m_k <= m_k + 1;
                end
            end
            m_valid <= 1'b1;
        end
    end

    function automatic logic [31:0] pix(input int k);
        int x;
        int y;
        logic [7:0] b;
        x = k % X;
        y = (k / X) % Y;
        b = shadow[0][7:0];
        if (shadow[1][0] && ((x % 32) == 0 || (y % 32) == 0)) b = 8'hFF;
        return {8'h00, 8'(x % 256), 8'(y % 256), b};
    endfunction

    function automatic logic [34:0] beat_exp(input int k);
        return {1'b1, (k == 0), ((k % X) == X - 1), pix(k)};
    endfunction

    task automatic run_beats(input int n, output int bad, output logic [34:0] got, output logic [34:0] exp);
        logic [34:0] g;
        logic [34:0] e;
        bad = 0;
        got = '0;
        exp = '0;
        out_stream_tready = 1'b1;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            g = {out_stream_tvalid, out_stream_tuser, out_stream_tlast, out_stream_tdata};
            e = beat_exp(m_k);
            if (g !== e) begin
                if (bad == 0) begin
                    got = g;
                    exp = e;
                end
                bad++;
            end
        end
    endtask

    task automatic axi_write(input logic [7:0] a, input logic [31:0] d, output logic [1:0] resp, output bit ok);
        awaddr  = a;
        wdata   = d;
        awvalid = 1'b1;
        wvalid  = 1'b1;
        bready  = 1'b1;
        resp    = 2'b11;
        ok      = 1'b0;
        for (int t = 0; t < 50; t++) begin
            @(negedge clk);
            if (awready && wready) begin
                ok = 1'b1;
                break;
            end
        end
        if (ok) begin
            @(negedge clk);
            awvalid = 1'b0;
            wvalid  = 1'b0;
            ok      = 1'b0;
            for (int t = 0; t < 50; t++) begin
                if (bvalid) begin
                    resp = bresp;
                    ok   = 1'b1;
                    break;
                end
                @(negedge clk);
            end
            if (a[4:2] != 3'd7) shadow[a[4:2]] = d;
        end
        awvalid = 1'b0;
        wvalid  = 1'b0;
        repeat (2) @(negedge clk);
        bready = 1'b0;
    endtask

    task automatic axi_read(input logic [7:0] a, output logic [31:0] d, output logic [1:0] resp, output bit ok);
        araddr  = a;
        arvalid = 1'b1;
        d       = '0;
        resp    = 2'b11;
        ok      = 1'b0;
        for (int t = 0; t < 50; t++) begin
            @(negedge clk);
            if (arready) begin
                ok = 1'b1;
                break;
            end
        end
        if (ok) begin
            @(negedge clk);
            arvalid = 1'b0;
            ok      = 1'b0;
            for (int t = 0; t < 50; t++) begin
                if (rvalid) begin
                    d    = rdata;
                    resp = rresp;
                    ok   = 1'b1;
                    break;
                end
                @(negedge clk);
            end
            rready = 1'b1;
            @(negedge clk);
            rready = 1'b0;
        end
        arvalid = 1'b0;
    endtask

    task automatic test_reset();
        out_stream_tready = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({out_stream_tvalid, out_stream_tuser, out_stream_tlast, out_stream_tdata} !== 35'd0) begin
            n_fail++;
            $display("FAIL reset_stream: got %h expected 0", {out_stream_tvalid, out_stream_tuser, out_stream_tlast, out_stream_tdata});
        end
        n_checks++;
        if (out_stream_tkeep !== 4'hF) begin
            n_fail++;
            $display("FAIL reset_tkeep: got %h expected f", out_stream_tkeep);
        end
        n_checks++;
        if ({awready, wready, arready, bvalid, rvalid, bresp, rresp, rdata} !== 41'd0) begin
            n_fail++;
            $display("FAIL reset_axi: got %h expected 0", {awready, wready, arready, bvalid, rvalid, bresp, rresp, rdata});
        end
        axi_resetn    = 1'b1;
        periph_resetn = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({out_stream_tvalid, out_stream_tuser, out_stream_tlast, out_stream_tdata} !== {3'b110, 32'h0}) begin
            n_fail++;
            $display("FAIL first_beat: got %h expected %h", {out_stream_tvalid, out_stream_tuser, out_stream_tlast, out_stream_tdata}, {3'b110, 32'h0});
        end
        $display("reset: released, first beat tdata=%h tuser=%b", out_stream_tdata, out_stream_tuser);
    endtask

    task automatic test_stall();
        int bad;
        logic [34:0] g;
        logic [34:0] e;
        run_beats(100, bad, g, e);
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL stall_lead_in: %0d beats off, got %h expected %h", bad, g, e);
        end
        out_stream_tready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            n_checks++;
            if ({out_stream_tvalid, out_stream_tdata} !== {1'b1, 32'h00640000}) begin
                n_fail++;
                $display("FAIL stall_hold: cycle %0d got %h expected %h", i, {out_stream_tvalid, out_stream_tdata}, {1'b1, 32'h00640000});
            end
        end
        out_stream_tready = 1'b1;
        @(negedge clk);
        n_checks++;
        if (out_stream_tdata !== 32'h00650000) begin
            n_fail++;
            $display("FAIL stall_resume: got %h expected 00650000", out_stream_tdata);
        end
        $display("stall: held 10 cycles at x=100, resumed tdata=%h", out_stream_tdata);
    endtask

    task automatic test_raster();
        int bad;
        logic [34:0] g;
        logic [34:0] e;
        run_beats(2 * X + 10, bad, g, e);
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL raster: %0d beats off, got %h expected %h", bad, g, e);
        end
        $display("raster: %0d beats compared, %0d off", 2 * X + 10, bad);
    endtask

    task automatic test_backpressure();
        int bad = 0;
        logic [34:0] g;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            g = {out_stream_tvalid, out_stream_tuser, out_stream_tlast, out_stream_tdata};
            if (g !== beat_exp(m_k)) begin
                if (bad == 0) $display("FAIL backpressure: cycle %0d got %h expected %h", i, g, beat_exp(m_k));
                bad++;
            end
            out_stream_tready = 1'($urandom_range(0, 1));
        end
        n_checks++;
        if (bad != 0) n_fail++;
        $display("backpressure: 300 random-ready cycles, %0d off", bad);
    endtask

    task automatic test_blue();
        int bad;
        logic [34:0] g;
        logic [34:0] e;
        logic [1:0]  r;
        logic [31:0] d;
        bit ok;
        axi_write(8'h00, 32'h000000AA, r, ok);
        n_checks++;
        if (!ok || r !== 2'b00) begin
            n_fail++;
            $display("FAIL blue_write: ok=%0d bresp %b expected 00", ok, r);
        end
        run_beats(XY, bad, g, e);
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL blue_frame: %0d beats off, got %h expected %h", bad, g, e);
        end
        out_stream_tready = 1'b0;
        @(negedge clk);
        axi_read(8'h1C, d, r, ok);
        n_checks++;
        if (!ok || d !== m_frames || r !== 2'b00) begin
            n_fail++;
            $display("FAIL frame_count: ok=%0d got %h expected %h", ok, d, m_frames);
        end
        $display("blue: full frame with B=AA, frame count read %0d", d);
    endtask

    task automatic test_grid();
        int bad;
        int n;
        logic [34:0] g;
        logic [34:0] e;
        logic [1:0]  r;
        logic [31:0] d;
        logic [7:0]  b;
        bit ok0;
        bit ok1;
        b = 8'($urandom_range(0, 254));
        d = $urandom;
        d[7:0] = b;
        axi_write(8'h00, d, r, ok0);
        axi_write(8'h04, 32'h00000001, r, ok1);
        n_checks++;
        if (!ok0 || !ok1) begin
            n_fail++;
            $display("FAIL grid_writes: ok %0d %0d expected 1 1", ok0, ok1);
        end
        n = ((5 * X + 32) - m_k + XY) % XY;
        if (n == 0) n = XY;
        run_beats(n, bad, g, e);
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL grid_run: %0d beats off, got %h expected %h", bad, g, e);
        end
        n_checks++;
        if (out_stream_tdata !== {8'h00, 8'd32, 8'd5, 8'hFF}) begin
            n_fail++;
            $display("FAIL grid_line: got %h expected %h", out_stream_tdata, {8'h00, 8'd32, 8'd5, 8'hFF});
        end
        run_beats(1, bad, g, e);
        n_checks++;
        if (out_stream_tdata !== {8'h00, 8'd33, 8'd5, b}) begin
            n_fail++;
            $display("FAIL grid_off: got %h expected %h", out_stream_tdata, {8'h00, 8'd33, 8'd5, b});
        end
        $display("grid: (32,5) and (33,5) checked with base blue %h", b);
    endtask

    task automatic test_regs();
        logic [1:0]  r;
        logic [31:0] d;
        logic [31:0] v;
        logic [7:0]  a;
        bit ok;
        int idx;
        out_stream_tready = 1'b0;
        axi_write(8'h0C, 32'h12345678, r, ok);
        axi_read(8'h0C, d, r, ok);
        n_checks++;
        if (!ok || d !== 32'h12345678 || r !== 2'b00) begin
            n_fail++;
            $display("FAIL reg3_read: got %h/%b expected 12345678/00", d, r);
        end
        axi_read(8'h2C, d, r, ok);
        n_checks++;
        if (!ok || d !== 32'h12345678 || r !== 2'b00) begin
            n_fail++;
            $display("FAIL reg3_alias: got %h/%b expected 12345678/00", d, r);
        end
        axi_write(8'h1C, $urandom, r, ok);
        axi_read(8'h1C, d, r, ok);
        n_checks++;
        if (!ok || d !== m_frames) begin
            n_fail++;
            $display("FAIL reg7_readonly: got %h expected %h", d, m_frames);
        end
        for (int i = 0; i < 8; i++) begin
            idx = $urandom_range(0, 6);
            v   = $urandom;
            a   = 8'($urandom_range(0, 7) * 32 + idx * 4 + $urandom_range(0, 3));
            axi_write(a, v, r, ok);
            a   = 8'($urandom_range(0, 7) * 32 + idx * 4);
            axi_read(a, d, r, ok);
            n_checks++;
            if (!ok || d !== shadow[idx]) begin
                n_fail++;
                $display("FAIL reg_random: reg%0d addr %h got %h expected %h", idx, a, d, shadow[idx]);
            end
            $display("regs: reg%0d <= %h read back %h", idx, v, d);
        end
    endtask

    task automatic test_back_to_back();
        logic [1:0]  rw;
        logic [1:0]  rr;
        logic [31:0] d;
        logic [31:0] exp2;
        bit okw;
        bit okr;
        exp2 = shadow[2];
        fork
            axi_write(8'h10, 32'hCAFE0004, rw, okw);
            axi_read(8'h08, d, rr, okr);
        join
        n_checks++;
        if (!okw || !okr || rw !== 2'b00 || d !== exp2) begin
            n_fail++;
            $display("FAIL simultaneous: ok %0d %0d read %h expected %h", okw, okr, d, exp2);
        end
        axi_read(8'h10, d, rr, okr);
        n_checks++;
        if (!okr || d !== 32'hCAFE0004) begin
            n_fail++;
            $display("FAIL simultaneous_wr: got %h expected cafe0004", d);
        end
        $display("back_to_back: parallel write reg4 / read reg2 done");
    endtask

    task automatic test_periph_reset();
        int bad;
        int n;
        logic [34:0] g;
        logic [34:0] e;
        logic [1:0]  r;
        logic [31:0] d;
        bit ok;
        n = ((200 % Y) * X + 300 % X - m_k + XY) % XY;
        if (n == 0) n = XY;
        run_beats(n, bad, g, e);
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL prst_lead_in: %0d beats off, got %h expected %h", bad, g, e);
        end
        periph_resetn = 1'b0;
        #1;
        n_checks++;
        if ({out_stream_tvalid, out_stream_tdata} !== 33'd0) begin
            n_fail++;
            $display("FAIL prst_async: got %h expected 0", {out_stream_tvalid, out_stream_tdata});
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_checks++;
            if (out_stream_tvalid !== 1'b0) begin
                n_fail++;
                $display("FAIL prst_hold: cycle %0d tvalid %b expected 0", i, out_stream_tvalid);
            end
        end
        periph_resetn = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({out_stream_tvalid, out_stream_tuser, out_stream_tdata} !== {2'b11, pix(0)}) begin
            n_fail++;
            $display("FAIL prst_restart: got %h expected %h", {out_stream_tvalid, out_stream_tuser, out_stream_tdata}, {2'b11, pix(0)});
        end
        out_stream_tready = 1'b0;
        @(negedge clk);
        axi_read(8'h1C, d, r, ok);
        n_checks++;
        if (!ok || d !== m_frames) begin
            n_fail++;
            $display("FAIL prst_frame_kept: got %h expected %h", d, m_frames);
        end
        run_beats(X + 5, bad, g, e);
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL prst_after: %0d beats off, got %h expected %h", bad, g, e);
        end
        $display("periph_reset: restart at (0,0), frame count %0d", d);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 8; i++) shadow[i] = '0;
        test_reset();
        test_stall();
        test_raster();
        test_backpressure();
        test_blue();
        test_grid();
        test_regs();
        test_back_to_back();
        test_periph_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
